// File: rtl/tag_stream_packetizer.sv
// Packetises a bare per-cycle tag strobe into an AXI-Stream master: one-entry
// hold stage decides tlast, an output FIFO absorbs backpressure and drops are counted.
module tag_stream_packetizer #(
  parameter int unsigned DATA_WIDTH    = 32,
  parameter int unsigned KEEP_WIDTH    = (DATA_WIDTH + 7) / 8,
  parameter int unsigned FIFO_DEPTH    = 64,
  parameter int unsigned MAX_PKT_LEN   = 256,
  parameter int unsigned FLUSH_TIMEOUT = 1024
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  tag_valid,
  input  logic [DATA_WIDTH-1:0] tag_data,
  input  logic [31:0]           wrap_count,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tlast,
  output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
  output logic [31:0]           m_axis_tuser,
  input  logic                  drop_clear,
  output logic [15:0]           drop_count,
  output logic                  overflow
);

  localparam int unsigned WRAP_W = 32;
  localparam int unsigned AW     = $clog2(FIFO_DEPTH);
  localparam int unsigned CW     = AW + 1;
  localparam int unsigned PW     = $clog2(MAX_PKT_LEN);
  localparam int unsigned TW     = $clog2(FLUSH_TIMEOUT);
  localparam int unsigned EW     = 1 + WRAP_W + DATA_WIDTH;

  localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);
  localparam logic [PW-1:0] PKT_LAST = PW'(MAX_PKT_LEN - 1);
  localparam logic [TW-1:0] TMO_MAX  = TW'(FLUSH_TIMEOUT - 1);

  // Reject illegal parameterisations at elaboration.
  if (DATA_WIDTH != 32) begin : g_bad_data_width
    $error("tag_stream_packetizer: DATA_WIDTH must be 32");
  end
  if (KEEP_WIDTH != (DATA_WIDTH + 7) / 8) begin : g_bad_keep_width
    $error("tag_stream_packetizer: KEEP_WIDTH must be (DATA_WIDTH+7)/8");
  end
  if ((FIFO_DEPTH < 4) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_fifo_depth
    $error("tag_stream_packetizer: FIFO_DEPTH must be a power of two >= 4");
  end
  if (MAX_PKT_LEN < 2) begin : g_bad_pkt_len
    $error("tag_stream_packetizer: MAX_PKT_LEN must be >= 2");
  end
  if (FLUSH_TIMEOUT < 2) begin : g_bad_timeout
    $error("tag_stream_packetizer: FLUSH_TIMEOUT must be >= 2");
  end

  logic                  r_hold_vld;
  logic [DATA_WIDTH-1:0] r_hold_data;
  logic [WRAP_W-1:0]     r_hold_wrap;
  logic [TW-1:0]         r_idle;
  logic [PW-1:0]         r_pkt_cnt;

  logic [EW-1:0]         r_mem [FIFO_DEPTH];
  logic [AW-1:0]         r_wr_ptr;
  logic [AW-1:0]         r_rd_ptr;
  logic [CW-1:0]         r_count;

  logic                  r_tvalid;
  logic [DATA_WIDTH-1:0] r_tdata;
  logic                  r_tlast;
  logic [WRAP_W-1:0]     r_tuser;
  logic [15:0]           r_drop_cnt;
  logic                  r_ovf;

  logic                  w_pop;
  logic                  w_room;
  logic                  w_expired;
  logic                  w_wr;
  logic                  w_wr_last;
  logic                  w_drop;
  logic                  w_hold_load;
  logic                  w_hold_clear;
  logic [EW-1:0]         w_wr_data;
  logic [AW-1:0]         w_rd_ptr_nxt;
  logic [CW-1:0]         w_count_nxt;
  logic [EW-1:0]         w_head_nxt;

  // Hold-stage decisions; a pop in the same cycle frees a slot for the write.
  always_comb begin
    w_pop        = r_tvalid && m_axis_tready;
    w_room       = (r_count != DEPTH_C) || w_pop;
    w_expired    = (r_idle == TMO_MAX);
    w_wr         = 1'b0;
    w_wr_last    = 1'b0;
    w_drop       = 1'b0;
    w_hold_load  = 1'b0;
    w_hold_clear = 1'b0;
    if (tag_valid) begin
      if (!r_hold_vld) begin
        w_hold_load = 1'b1;
      end else if (w_room) begin
        w_wr        = 1'b1;
        w_wr_last   = (r_pkt_cnt == PKT_LAST) || (wrap_count != r_hold_wrap);
        w_hold_load = 1'b1;
      end else begin
        w_drop = 1'b1;
      end
    end else if (r_hold_vld && w_expired && w_room) begin
      w_wr         = 1'b1;
      w_wr_last    = 1'b1;
      w_hold_clear = 1'b1;
    end
  end

  // FIFO bookkeeping; the head bypasses the array when the FIFO drains to empty.
  always_comb begin
    w_wr_data    = {w_wr_last, r_hold_wrap, r_hold_data};
    w_rd_ptr_nxt = w_pop ? (r_rd_ptr + AW'(1)) : r_rd_ptr;
    w_count_nxt  = r_count + CW'(w_wr) - CW'(w_pop);
    if (r_count == CW'(w_pop)) begin
      w_head_nxt = w_wr_data;
    end else begin
      w_head_nxt = r_mem[w_rd_ptr_nxt];
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_mem[r_wr_ptr] <= w_wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_tvalid <= 1'b0;
      r_tdata  <= '0;
      r_tlast  <= 1'b0;
      r_tuser  <= '0;
    end else begin
      if (w_wr) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      r_rd_ptr <= w_rd_ptr_nxt;
      r_count  <= w_count_nxt;
      r_tvalid <= (w_count_nxt != '0);
      if (w_count_nxt != '0) begin
        {r_tlast, r_tuser, r_tdata} <= w_head_nxt;
      end
    end
  end

  // Hold register, idle timer and packet beat counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hold_vld  <= 1'b0;
      r_hold_data <= '0;
      r_hold_wrap <= '0;
      r_idle      <= '0;
      r_pkt_cnt   <= '0;
    end else begin
      if (w_hold_load) begin
        r_hold_vld  <= 1'b1;
        r_hold_data <= tag_data;
        r_hold_wrap <= wrap_count;
      end else if (w_hold_clear) begin
        r_hold_vld <= 1'b0;
      end
      if (tag_valid || w_hold_clear) begin
        r_idle <= '0;
      end else if (r_hold_vld && !w_expired) begin
        r_idle <= r_idle + TW'(1);
      end
      if (w_wr) begin
        r_pkt_cnt <= w_wr_last ? '0 : (r_pkt_cnt + PW'(1));
      end
    end
  end

  // Drop statistics; a drop coinciding with a clear is still counted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_drop_cnt <= '0;
      r_ovf      <= 1'b0;
    end else if (drop_clear) begin
      r_drop_cnt <= w_drop ? 16'd1 : 16'd0;
      r_ovf      <= w_drop;
    end else if (w_drop) begin
      if (r_drop_cnt != 16'hFFFF) begin
        r_drop_cnt <= r_drop_cnt + 16'd1;
      end
      r_ovf <= 1'b1;
    end
  end

  assign m_axis_tvalid = r_tvalid;
  assign m_axis_tdata  = r_tdata;
  assign m_axis_tlast  = r_tlast;
  assign m_axis_tuser  = r_tuser;
  assign m_axis_tkeep  = {KEEP_WIDTH{1'b1}};
  assign drop_count    = r_drop_cnt;
  assign overflow      = r_ovf;

endmodule

// File: tb/tb_tag_stream_packetizer.sv
// Scoreboard bench for tag_stream_packetizer: a queue-based reference model
// predicts beats and drop statistics; a negedge monitor compares each handshake.
module tb_tag_stream_packetizer;

  localparam int D    = 8;
  localparam int MAXP = 4;
  localparam int T    = 16;

  typedef struct packed {
    logic        last;
    logic [31:0] user;
    logic [31:0] data;
  } beat_t;

  typedef struct {
    beat_t b;
    int    cyc;
  } log_t;

  logic        clk;
  logic        rst_n;
  logic        tag_valid;
  logic [31:0] tag_data;
  logic [31:0] wrap_count;
  logic        m_axis_tvalid;
  logic        m_axis_tready;
  logic [31:0] m_axis_tdata;
  logic        m_axis_tlast;
  logic [3:0]  m_axis_tkeep;
  logic [31:0] m_axis_tuser;
  logic        drop_clear;
  logic [15:0] drop_count;
  logic        overflow;

  tag_stream_packetizer #(
    .DATA_WIDTH(32), .KEEP_WIDTH(4), .FIFO_DEPTH(D),
    .MAX_PKT_LEN(MAXP), .FLUSH_TIMEOUT(T)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .tag_valid(tag_valid), .tag_data(tag_data), .wrap_count(wrap_count),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tlast(m_axis_tlast),
    .m_axis_tkeep(m_axis_tkeep), .m_axis_tuser(m_axis_tuser),
    .drop_clear(drop_clear), .drop_count(drop_count), .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int    checks = 0;
  int    errors = 0;
  int    cyc = 0;
  bit    exp_tvalid = 1'b0;
  beat_t sb_q[$];
  log_t  beat_log[$];

  // Reference model state: hold stage, FIFO occupancy, packet length, drops.
  bit          h_vld = 1'b0;
  logic [31:0] h_data = '0;
  logic [31:0] h_wrap = '0;
  int          last_arr = 0;
  int          mq_cnt = 0;
  int          pkt_beats = 0;
  int          exp_drops = 0;
  bit          exp_ovf = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_clear();
    h_vld = 1'b0; mq_cnt = 0; pkt_beats = 0;
    exp_drops = 0; exp_ovf = 1'b0;
    sb_q.delete();
  endtask

  // Drive one cycle of stimulus and advance the model across the coming edge.
  task automatic step(input bit tv, input logic [31:0] td, input logic [31:0] tw,
                      input bit rdy, input bit clr);
    bit    pop, room, wr, drop;
    beat_t b;
    exp_tvalid    = (mq_cnt > 0);
    tag_valid     = tv;
    tag_data      = td;
    wrap_count    = tw;
    m_axis_tready = rdy;
    drop_clear    = clr;
    pop  = rdy && (mq_cnt > 0);
    room = (mq_cnt < D) || pop;
    wr = 1'b0; drop = 1'b0; b = '0;
    if (tv) begin
      if (!h_vld) begin
        h_vld = 1'b1; h_data = td; h_wrap = tw;
      end else if (room) begin
        b = '{last: (pkt_beats == MAXP - 1) || (tw != h_wrap), user: h_wrap, data: h_data};
        wr = 1'b1; h_data = td; h_wrap = tw;
      end else begin
        drop = 1'b1;
      end
      last_arr = cyc;
    end else if (h_vld && ((cyc - last_arr) >= T) && room) begin
      b = '{last: 1'b1, user: h_wrap, data: h_data};
      wr = 1'b1; h_vld = 1'b0;
    end
    if (wr) begin
      sb_q.push_back(b);
      pkt_beats = b.last ? 0 : pkt_beats + 1;
    end
    mq_cnt = mq_cnt + int'(wr) - int'(pop);
    if (clr) begin
      exp_drops = drop ? 1 : 0;
      exp_ovf   = drop;
    end else if (drop) begin
      if (exp_drops < 65535) exp_drops++;
      exp_ovf = 1'b1;
    end
    @(posedge clk); #1;
    cyc++;
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++) step(1'b0, 32'd0, 32'd0, rdy, 1'b0);
  endtask

  task automatic chk_stats(input string name);
    chk({name, "_drop_count"}, 32'(drop_count), 32'(exp_drops));
    chk({name, "_overflow"}, 32'(overflow), 32'(exp_ovf));
  endtask

  // Monitor: tvalid timing, stall stability and beat contents against the scoreboard.
  bit          prev_stall = 1'b0;
  logic [31:0] prev_data;
  logic        prev_last;
  logic [31:0] prev_user;
  initial begin
    beat_t e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        chk("tvalid", 32'(m_axis_tvalid), 32'(exp_tvalid));
        if (prev_stall) begin
          chk("stall_tdata", m_axis_tdata, prev_data);
          chk("stall_tlast", 32'(m_axis_tlast), 32'(prev_last));
          chk("stall_tuser", m_axis_tuser, prev_user);
        end
        if (m_axis_tvalid && m_axis_tready) begin
          if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_beat: got data %h with no beat expected (cycle %0d)",
                     m_axis_tdata, cyc);
          end else begin
            e = sb_q.pop_front();
            chk("beat_tdata", m_axis_tdata, e.data);
            chk("beat_tlast", 32'(m_axis_tlast), 32'(e.last));
            chk("beat_tuser", m_axis_tuser, e.user);
            chk("beat_tkeep", 32'(m_axis_tkeep), 32'hF);
          end
          beat_log.push_back('{b: '{last: m_axis_tlast, user: m_axis_tuser, data: m_axis_tdata},
                               cyc: cyc});
        end
        prev_stall = m_axis_tvalid && !m_axis_tready;
        prev_data  = m_axis_tdata;
        prev_last  = m_axis_tlast;
        prev_user  = m_axis_tuser;
      end else begin
        prev_stall = 1'b0;
      end
    end
  end

  initial begin
    int          base;
    logic [31:0] tags [D + 3];
    logic [31:0] rwrap;

    rst_n = 1'b0; tag_valid = 1'b0; tag_data = '0; wrap_count = '0;
    m_axis_tready = 1'b0; drop_clear = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tvalid", 32'(m_axis_tvalid), 32'd0);
    chk("rst_tdata", m_axis_tdata, 32'd0);
    chk("rst_tlast", 32'(m_axis_tlast), 32'd0);
    chk("rst_tuser", m_axis_tuser, 32'd0);
    chk("rst_tkeep", 32'(m_axis_tkeep), 32'hF);
    chk("rst_drop_count", 32'(drop_count), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    rst_n = 1'b1;

    // Length limit: 9 tags of wrap 5 close at beats 4, 8 and on timeout for beat 9.
    base = beat_log.size();
    for (int i = 0; i < 9; i++) step(1'b1, $urandom, 32'd5, 1'b1, 1'b0);
    idle(T + 4, 1'b1);
    chk("len_beats", 32'(beat_log.size() - base), 32'd9);
    if (beat_log.size() - base == 9) begin
      for (int i = 0; i < 9; i++) begin
        chk("len_tlast", 32'(beat_log[base + i].b.last), 32'((i == 3) || (i == 7) || (i == 8)));
        chk("len_tuser", beat_log[base + i].b.user, 32'd5);
      end
      chk("len_timeout_gap", 32'(beat_log[base + 8].cyc - beat_log[base + 7].cyc), 32'(T));
    end

    // Wrap change closes the packet early.
    base = beat_log.size();
    step(1'b1, 32'hA, 32'd7, 1'b1, 1'b0);
    step(1'b1, 32'hB, 32'd7, 1'b1, 1'b0);
    step(1'b1, 32'hC, 32'd8, 1'b1, 1'b0);
    idle(T + 4, 1'b1);
    chk("wrap_beats", 32'(beat_log.size() - base), 32'd3);
    if (beat_log.size() - base == 3) begin
      chk("wrap_b_tlast", 32'(beat_log[base + 1].b.last), 32'd1);
      chk("wrap_b_tuser", beat_log[base + 1].b.user, 32'd7);
      chk("wrap_c_data", beat_log[base + 2].b.data, 32'hC);
      chk("wrap_c_tlast", 32'(beat_log[base + 2].b.last), 32'd1);
      chk("wrap_c_tuser", beat_log[base + 2].b.user, 32'd8);
    end

    // Backpressure: D in FIFO, 1 in hold, 2 dropped, then back-to-back drain.
    base = beat_log.size();
    for (int i = 0; i < D + 3; i++) begin
      tags[i] = $urandom;
      step(1'b1, tags[i], 32'd9, 1'b0, 1'b0);
    end
    idle(T + 4, 1'b0);
    chk("bp_drop_count", 32'(drop_count), 32'd2);
    chk("bp_overflow", 32'(overflow), 32'd1);
    chk("bp_no_beats", 32'(beat_log.size() - base), 32'd0);
    idle(D + 6, 1'b1);
    chk("bp_beats", 32'(beat_log.size() - base), 32'(D + 1));
    if (beat_log.size() - base == D + 1) begin
      for (int i = 0; i <= D; i++) begin
        chk("bp_order", beat_log[base + i].b.data, tags[i]);
        chk("bp_no_gap", 32'(beat_log[base + i].cyc - beat_log[base].cyc), 32'(i));
      end
    end

    // Drop statistics: clear colliding with a drop, plain clear, saturation.
    step(1'b0, 32'd0, 32'd9, 1'b1, 1'b1);
    chk_stats("clr");
    for (int i = 0; i < D + 1 + 3; i++) step(1'b1, $urandom, 32'd9, 1'b0, 1'b0);
    chk("drop3_count", 32'(drop_count), 32'd3);
    step(1'b1, $urandom, 32'd9, 1'b0, 1'b1);
    chk("clr_drop_count", 32'(drop_count), 32'd1);
    chk("clr_drop_overflow", 32'(overflow), 32'd1);
    step(1'b0, 32'd0, 32'd9, 1'b0, 1'b1);
    chk("clr_only_count", 32'(drop_count), 32'd0);
    chk("clr_only_overflow", 32'(overflow), 32'd0);
    for (int i = 0; i < 70000; i++) step(1'b1, $urandom, 32'd9, 1'b0, 1'b0);
    chk("sat_drop_count", 32'(drop_count), 32'hFFFF);
    chk("sat_overflow", 32'(overflow), 32'd1);
    idle(T + D + 6, 1'b1);

    // Tag arriving on the exact expiry cycle takes the arrival path.
    base = beat_log.size();
    step(1'b1, 32'h1111, 32'd3, 1'b1, 1'b0);
    idle(T - 1, 1'b1);
    step(1'b1, 32'h2222, 32'd3, 1'b1, 1'b0);
    idle(T + 4, 1'b1);
    chk("race_beats", 32'(beat_log.size() - base), 32'd2);
    if (beat_log.size() - base == 2) begin
      chk("race_x_tlast", 32'(beat_log[base].b.last), 32'd0);
      chk("race_y_tlast", 32'(beat_log[base + 1].b.last), 32'd1);
      chk("race_timer_restart", 32'(beat_log[base + 1].cyc - beat_log[base].cyc), 32'(T));
    end

    // Randomised traffic: dense then sparse tags, random ready and clears.
    rwrap = 32'd20;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 19) == 0) rwrap++;
      step($urandom_range(0, 2) != 0, $urandom, rwrap, $urandom_range(0, 3) != 0,
           $urandom_range(0, 49) == 0);
    end
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 29) == 0) rwrap++;
      step($urandom_range(0, 19) == 0, $urandom, rwrap, $urandom_range(0, 1) != 0, 1'b0);
    end
    idle(T + D + 6, 1'b1);
    chk_stats("rand");

    // Asynchronous reset with beats queued under backpressure.
    for (int i = 0; i < 4; i++) step(1'b1, $urandom, 32'd2, 1'b0, 1'b0);
    idle(2, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_tvalid", 32'(m_axis_tvalid), 32'd0);
    chk("mid_rst_tlast", 32'(m_axis_tlast), 32'd0);
    chk("mid_rst_tdata", m_axis_tdata, 32'd0);
    chk("mid_rst_tuser", m_axis_tuser, 32'd0);
    chk("mid_rst_drop_count", 32'(drop_count), 32'd0);
    chk("mid_rst_overflow", 32'(overflow), 32'd0);
    model_clear();
    exp_tvalid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    base = beat_log.size();
    for (int i = 0; i < 5; i++) step(1'b1, $urandom, 32'd1, 1'b1, 1'b0);
    idle(T + 4, 1'b1);
    chk("post_rst_beats", 32'(beat_log.size() - base), 32'd5);
    if (beat_log.size() - base == 5) begin
      for (int i = 0; i < 5; i++) begin
        chk("post_rst_tlast", 32'(beat_log[base + i].b.last), 32'((i == 3) || (i == 4)));
        chk("post_rst_tuser", beat_log[base + i].b.user, 32'd1);
      end
    end

    chk("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/tag_stream_packetizer.md
Name: tag_stream_packetizer

Overview:
- Transmit-side counterpart of the tag-consuming user logic: turns a bare per-cycle tag strobe into a packetised AXI-Stream 4 master stream.
- Each word carries tkeep = all ones and tuser = wrap count; tlast closes packets; tuser changes only after a tlast beat.
- Absorbs downstream backpressure in a FIFO and reports dropped tags.
- Feeds sample/test designs and the loopback bench.

Parameters:
- DATA_WIDTH, 32, tag word width; only 32 is legal, anything else is an elaboration error.
- KEEP_WIDTH, (DATA_WIDTH+7)/8, tkeep width.
- FIFO_DEPTH, 64, output FIFO entries; power of two, minimum 4.
- MAX_PKT_LEN, 256, maximum beats per packet; minimum 2.
- FLUSH_TIMEOUT, 1024, idle cycles before a held tag is force-closed as the last beat; minimum 2.

Ports:
- clk  in  1  single clock for the whole block.
- rst_n  in  1  asynchronous, active-low reset.
- tag_valid  in  1  new tag this cycle; no backpressure to the source.
- tag_data  in  DATA_WIDTH  tag word.
- wrap_count  in  32  epoch of tag_data, sampled together with it.
- m_axis_tvalid  out  1  AXI-Stream valid.
- m_axis_tready  in  1  AXI-Stream ready.
- m_axis_tdata  out  DATA_WIDTH  tag word.
- m_axis_tlast  out  1  last beat of the packet.
- m_axis_tkeep  out  KEEP_WIDTH  constant all ones.
- m_axis_tuser  out  32  wrap count of the beat; constant within a packet.
- drop_clear  in  1  synchronous clear of the drop statistics.
- drop_count  out  16  saturating count of dropped tags.
- overflow  out  1  sticky flag: at least one tag dropped.

Behaviour:
- Reset (async assert, sync release): FIFO empty; hold register empty; pkt_cnt = 0; idle timer = 0; m_axis_tvalid = 0; m_axis_tlast = 0; m_axis_tdata = 0; m_axis_tuser = 0; drop_count = 0; overflow = 0. Reset mid-packet discards all held and queued data without emitting tlast.
- Hold stage: one-entry register {data, wrap}. The tlast decision for the held tag is made when the next tag arrives or on timeout.
- New tag, hold empty: tag loads into hold; the FIFO is not written.
- New tag, hold full, FIFO not full:
  - Held tag is written to the FIFO; new tag loads into hold.
  - Written last = (pkt_cnt == MAX_PKT_LEN-1) || (new wrap != held wrap).
- New tag, hold full, FIFO full: new tag is dropped; hold unchanged.
- Timeout, idle timer:
  - Increments each cycle the hold is full and no tag arrives.
  - Resets to 0 on every tag arrival.
  - At FLUSH_TIMEOUT-1 the timer is expired and saturates there.
- Timeout write: if expired and FIFO not full, the held tag is written with last=1 and the hold empties. If the FIFO is full, the flush waits, still expired.
- Tag arrival and expiry in the same cycle: arrival path wins; timer restarts.
- pkt_cnt: +1 per FIFO write; reset to 0 on a write with last=1. A packet therefore never exceeds MAX_PKT_LEN beats.
- FIFO entry: {last, wrap, data}; first-word-fall-through.
  - m_axis_tvalid = FIFO non-empty, registered.
  - Latency from FIFO write to tvalid is 1 cycle.
  - Minimum tag-in to tvalid latency is 2 cycles (arrival of the next tag or timeout + 1).
- Handshake:
  - Beat pops on tvalid && tready.
  - tdata/tlast/tuser stay stable while tvalid && !tready.
  - Full throughput of 1 beat/cycle when tready is held high.
  - Simultaneous FIFO write and pop when full is legal.
- Drop statistics: drop_count saturates at 16'hFFFF; overflow is sticky.
- drop_clear: zeroes drop_count and overflow. A drop in the same cycle wins: drop_count = 1, overflow = 1.
- Invariant: no FIFO entry with last=1 is ever dropped, so every emitted packet is terminated and tuser never changes mid-packet.

Test Plan:
- Packet length limit: MAX_PKT_LEN=4, tready=1, 9 tags with wrap=5 on consecutive cycles, then idle.
  - Required: beats 4 and 8 carry tlast.
  - Beat 9 carries tlast after FLUSH_TIMEOUT idle cycles.
  - tuser = 5 on all beats.
- Wrap change: tags A,B with wrap 7, then C with wrap 8.
  - Required: B emitted with tlast=1, tuser=7.
  - C emitted with tuser=8 and closes on timeout.
- Backpressure stability: tready=0 while FIFO_DEPTH+3 tags arrive.
  - Required: tdata/tlast/tuser stable while stalled.
  - drop_count = 2 (FIFO_DEPTH in FIFO, 1 in hold, 2 dropped), overflow = 1.
  - After tready=1, FIFO_DEPTH+1 beats out in order with no gaps.
- Drop statistics edge cases:
  - drop_clear in the same cycle as a drop: drop_count = 1, overflow = 1.
  - Force 70000 drops: drop_count = 16'hFFFF.
- Timer/arrival race: a tag arrives on the exact expiry cycle.
  - Required: no timeout write; held tag written with last per the length/wrap rule; timer back to 0.
- Reset mid-packet: rst_n low asynchronously with 3 beats queued and tready=0.
  - Required: m_axis_tvalid = 0 immediately, all state cleared.
  - The first packet after release starts with pkt_cnt = 0.
